// File: rtl/decoder_3to8_dispatch.sv
// Rotating-priority dispatcher: queues encoded 3-bit requests as a pending set
// and issues one-hot grants, each held until acknowledged or abandoned on timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant outstanding; pick next pending index if any
// ST_GRANT | one-hot grant held; wait for ack or hold timeout
module decoder_3to8_dispatch #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_y,
    output logic       in_ready,
    output logic [7:0] out_onehot,
    output logic       out_valid,
    input  logic       out_ack,
    output logic [7:0] pending,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_TC  = 8'(ACK_TIMEOUT - 1);

    logic [0:0] state;
    logic [2:0] last_served;
    logic [2:0] cur_sel;
    logic [7:0] hold_cnt;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    logic       accept;
    logic       grant_now;
    logic [7:0] pend_set;
    logic [7:0] pend_clr;

    assign in_ready  = (pending != 8'hFF);
    assign accept    = in_valid && in_ready;
    assign grant_now = (state == ST_IDLE) && found;
    assign pend_set  = accept ? (8'b1 << in_y) : 8'h00;
    assign pend_clr  = grant_now ? (8'b1 << sel) : 8'h00;

    // Search upward from last_served+1; the last index visited is last_served itself.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_served + 3'(i);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pending     <= 8'h00;
            out_onehot  <= 8'h00;
            out_valid   <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= 8'd0;
            last_served <= 3'd7;
            cur_sel     <= 3'd0;
        end else begin
            timeout <= 1'b0;
            // A set in the same cycle as the grant's clear keeps the bit pending.
            pending <= (pending & ~pend_clr) | pend_set;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        out_onehot <= 8'b1 << sel;
                        out_valid  <= 1'b1;
                        cur_sel    <= sel;
                        hold_cnt   <= 8'd0;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (out_ack) begin
                        out_onehot  <= 8'h00;
                        out_valid   <= 1'b0;
                        last_served <= cur_sel;
                        state       <= ST_IDLE;
                    end else if (hold_cnt == HOLD_TC) begin
                        timeout     <= 1'b1;
                        out_onehot  <= 8'h00;
                        out_valid   <= 1'b0;
                        last_served <= cur_sel;
                        state       <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/decoder_3to8_dispatch.md
DECODER_3TO8_DISPATCH -- requirements
Module: decoder_3to8_dispatch

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 15, the number of GRANT cycles without acknowledge before the grant is abandoned (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  encoded request present (driven from a priority encoder's valid output).
REQ-005 Port: in_y  input  3  encoded request index 0..7.
REQ-006 Port: in_ready  output  1  request accepted this cycle when in_valid and in_ready are both high.
REQ-007 Port: out_onehot  output  8  decoded one-hot grant; bit k set means index k is granted.
REQ-008 Port: out_valid  output  1  grant active.
REQ-009 Port: out_ack  input  1  consumer acknowledge of the current grant.
REQ-010 Port: pending  output  8  registered set of accepted, not-yet-granted indices.
REQ-011 Port: timeout  output  1  one-cycle pulse when a grant is abandoned.

Function
REQ-012 in_ready SHALL be combinational, equal to (pending != 8'hFF).
REQ-013 An accepted request SHALL set pending[in_y] on the next edge; a request for an already-set bit SHALL be merged (no count kept, no error).
REQ-014 FSM states SHALL be IDLE and GRANT only.
REQ-015 IDLE with registered pending == 0: the block SHALL remain in IDLE, with out_valid=0 and out_onehot=0.
REQ-016 IDLE with pending != 0: the block SHALL select sel, the first set bit searching upward from (last_served+1) mod 8 with wrap-around from 7 to 0.
REQ-017 On that same edge the block SHALL load out_onehot=1<<sel, set out_valid=1, clear pending[sel], and enter GRANT.
REQ-018 Latency: a request accepted at edge N with the block idle and pending empty SHALL produce out_valid high after edge N+1.
REQ-019 Simultaneous set and clear of the same pending bit SHALL resolve with the set winning, so the bit remains pending.
REQ-020 GRANT: out_onehot and out_valid SHALL hold stable until exit.
REQ-021 GRANT with out_ack=1: next edge SHALL clear out_valid and out_onehot, set last_served=sel, and return to IDLE.
REQ-022 The minimum spacing between consecutive grants SHALL be one idle cycle.
REQ-023 GRANT SHALL count cycles without ack; when the count reaches ACK_TIMEOUT, the next edge SHALL pulse timeout=1 for one cycle, drop the grant, set last_served=sel, and return to IDLE.
REQ-024 On timeout the dropped index SHALL NOT be re-queued.
REQ-025 If out_ack arrives in the cycle the count reaches ACK_TIMEOUT, ack SHALL win and timeout SHALL stay 0.
REQ-026 out_ack SHALL be ignored in IDLE.
REQ-027 The hold counter SHALL reset to 0 on every entry to GRANT.
REQ-028 out_onehot SHALL always be either zero or exactly one bit set.
REQ-029 Request acceptance SHALL continue in both states, independent of the FSM.

Reset
REQ-030 While rst_n=0 at an edge: state=IDLE, pending=0, out_onehot=0, out_valid=0, timeout=0, hold counter=0, last_served=7 (first search starts at index 0).
REQ-031 Reset asserted during GRANT SHALL discard the grant and all pending requests; no timeout pulse is produced.
REQ-032 Requests presented while rst_n=0 SHALL be ignored.

Verification
REQ-033 Reset, then in_y=3 for one cycle with immediate ack -> out_onehot=8'b00001000 two edges after acceptance, pending returns to 0, and the next grant search starts at index 4.
REQ-034 Load pending=8'b10000011 with last_served=0 -> grants in order index 1, 7, 0 (wrap-around), each on one-hot output.
REQ-035 Grant index 5 with out_ack held low, ACK_TIMEOUT=15 -> timeout high exactly one cycle, out_valid low thereafter, pending[5]=0.
REQ-036 Fill all eight indices while the first grant is held -> in_ready=0 while pending=8'hFF, then high the cycle after the next grant clears a bit.
REQ-037 Request for index k arrives in the same cycle k is granted -> pending[k]=1 afterwards and k is granted again later; then rst_n=0 mid-GRANT -> all outputs 0 next edge.
